// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the multi-cycle CPU ALU: op-code encodings, FSM state
// encoding and op classification.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Op/result handshake bundle between the CPU control path and the ALU.
// master = op producer / result consumer, slave = the ALU.
interface multicycle_alu_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] op;
    logic [WIDTH-1:0]  input1;
    logic [WIDTH-1:0]  input2;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  aluRes;
    logic              zero;
    logic              illegal;

    modport master (
        output in_valid, op, input1, input2, out_ready,
        input  in_ready, out_valid, aluRes, zero, illegal
    );

    modport slave (
        input  in_valid, op, input1, input2, out_ready,
        output in_ready, out_valid, aluRes, zero, illegal
    );
endinterface

// File: rtl/multicycle_alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// Compiled only when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CTRL_W-1:0] op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result
);

    localparam int CNT_W = $clog2(WIDTH);

    logic              busy_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic [CTRL_W-1:0] op_p1;
    // acc: partial product / remainder; sh: multiplicand / dividend->quotient;
    // opb: multiplier / divisor
    logic [WIDTH-1:0]  acc_p1, sh_p1, opb_p1;
    logic [WIDTH-1:0]  acc_n, sh_n, opb_n;
    logic [WIDTH:0]    trial, diff;
    logic              ge;

    always_comb begin
        trial = {acc_p1, sh_p1[WIDTH-1]};
        diff  = trial - {1'b0, opb_p1};
        ge    = ~diff[WIDTH];
        if (op_p1 == OP_MUL) begin
            acc_n = acc_p1 + (opb_p1[0] ? sh_p1 : '0);
            sh_n  = sh_p1 << 1;
            opb_n = opb_p1 >> 1;
        end else begin
            // A zero divisor always "fits": quotient fills with ones and the
            // remainder ends up as the dividend, which is the required result.
            acc_n = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            sh_n  = {sh_p1[WIDTH-2:0], ge};
            opb_n = opb_p1;
        end
    end

    // result is the post-iteration value so the caller can register it on
    // the same edge as the final iteration
    always_comb begin
        result = acc_n;
        if (op_p1 == OP_DIVU) result = sh_n;
    end

    assign busy = busy_p1;
    assign done = busy_p1 && (cnt_p1 == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_p1 <= 1'b0;
            cnt_p1  <= '0;
        end else if (start) begin
            busy_p1 <= 1'b1;
            cnt_p1  <= '0;
        end else if (busy_p1) begin
            cnt_p1 <= cnt_p1 + 1'b1;
            if (done) busy_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            op_p1  <= op;
            acc_p1 <= '0;
            sh_p1  <= a;
            opb_p1 <= b;
        end else if (busy_p1) begin
            acc_p1 <= acc_n;
            sh_p1  <= sh_n;
            opb_p1 <= opb_n;
        end
    end

endmodule
`endif

// File: rtl/multicycle_alu.sv
// Registered ALU for the multi-cycle CPU datapath with valid/ready handshakes.
// Define ALU_MULDIV_EN to enable the iterative MUL/DIVU/REMU ops.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input logic             clk,
    input logic             reset,
    multicycle_alu_if.slave bus
);

`ifdef ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    alu_state_e       state, state_n;
    logic             in_ready, accept, mc_op;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH:0]   single_v;
    logic [WIDTH-1:0] res_p1;
    logic             zero_p1, illegal_p1;

    // Returns {illegal, result}; multi-cycle codes land in default when disabled.
    function automatic logic [WIDTH:0] alu_single(input logic [CTRL_W-1:0] op,
                                                  input logic [WIDTH-1:0]  a,
                                                  input logic [WIDTH-1:0]  b);
        logic signed [WIDTH-1:0] sa, sb;
        logic [WIDTH-1:0]        r;
        logic                    ill;
        sa  = a;
        sb  = b;
        r   = '0;
        ill = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    assign mc_op    = MD_EN && is_multicycle(bus.op);
    assign single_v = alu_single(bus.op, bus.input1, bus.input2);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_n = mc_op ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                // never stall here if the iterator is not running
                if (md_done)      state_n = ST_DONE;
                else if (!md_busy) state_n = ST_IDLE;
            end
            ST_DONE: begin
                in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) state_n = mc_op ? ST_BUSY : ST_DONE;
                    else              state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

`ifdef ALU_MULDIV_EN
    logic start_md;
    assign start_md = accept && mc_op;

    alu_muldiv_iter #(
        .WIDTH  (WIDTH),
        .CTRL_W (CTRL_W)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (start_md),
        .op     (bus.op),
        .a      (bus.input1),
        .b      (bus.input2),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
`endif

    // Result stage: the visible outputs, cleared by reset so an aborted op
    // never leaves a value behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_p1     <= '0;
            zero_p1    <= 1'b0;
            illegal_p1 <= 1'b0;
        end else if (accept && !mc_op) begin
            res_p1     <= single_v[WIDTH-1:0];
            zero_p1    <= (single_v[WIDTH-1:0] == '0);
            illegal_p1 <= single_v[WIDTH];
        end else if ((state == ST_BUSY) && md_done) begin
            res_p1     <= md_result;
            zero_p1    <= (md_result == '0);
            illegal_p1 <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.aluRes    = res_p1;
    assign bus.zero      = zero_p1;
    assign bus.illegal   = illegal_p1;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=32); follows ALU_MULDIV_EN.
module tb_multicycle_alu;

    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_alu_if #(.WIDTH(W), .CTRL_W(4)) bus ();
    multicycle_alu #(.WIDTH(W), .CTRL_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.res = '0;
        e.ill = 1'b0;
        case (op)
            4'h0: e.res = a & b;
            4'h1: e.res = a | b;
            4'h2: e.res = a + b;
            4'h6: e.res = a - b;
            4'h7: e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'h8: e.res = (a < b) ? W'(1) : W'(0);
            4'h9: if (MD) e.res = a * b; else e.ill = 1'b1;
            4'hA: if (MD) e.res = (b == 0) ? '1 : a / b; else e.ill = 1'b1;
            4'hB: if (MD) e.res = (b == 0) ? a : a % b; else e.ill = 1'b1;
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
        return (MD && (op == 4'h9 || op == 4'hA || op == 4'hB)) ? W + 1 : 1;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge with inputs scrambled.
    task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.input1 = a;
        bus.input2 = b;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout op=%h in_ready=%b required=1", op, bus.in_ready);
        end else begin
            sb_q.push_back(model(op, a, b));
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op = 4'hC;
        bus.input1 = $urandom;
        bus.input2 = $urandom;
    endtask

    task automatic wait_out(output int lat, output bit sawr);
        lat = 1;
        sawr = 1'b0;
        #1;
        while (!bus.out_valid && lat < 200) begin
            sawr |= bus.in_ready;
            @(negedge clk); #1; lat++;
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output exp_t e, output int lat, output bit sawr);
        drive_op(op, a, b);
        wait_out(lat, sawr);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = 4'h0;
        bus.input1 = '0;
        bus.input2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b required=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b required=0", bus.out_valid); end
        checks++; if (bus.aluRes !== '0) begin failures++; $display("FAIL reset_aluRes got=%h required=0", bus.aluRes); end
        checks++; if (bus.zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b required=0", bus.zero); end
        checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b required=0", bus.illegal); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_cycle;
        logic [3:0]   ops [10] = '{4'h2, 4'h6, 4'h7, 4'h8, 4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h7};
        logic [W-1:0] as  [10] = '{32'd5, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0FF00,
                                   32'hF0F0FF00, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h80000000};
        logic [W-1:0] bs  [10] = '{32'd7, 32'h3, 32'h1, 32'h1, 32'h0FF0F0F0,
                                   32'h0FF0F0F0, 32'h1, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF};
        exp_t e;
        int   lat;
        bit   sawr;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], as[i], bs[i], e, lat, sawr);
            checks++;
            if (bus.aluRes !== e.res || bus.zero !== e.z || bus.illegal !== e.ill) begin
                failures++;
                $display("FAIL single_result op=%h got=%h/%b/%b required=%h/%b/%b", ops[i],
                         bus.aluRes, bus.zero, bus.illegal, e.res, e.z, e.ill);
            end
            checks++;
            if (lat != 1) begin failures++; $display("FAIL single_latency op=%h got=%0d required=1", ops[i], lat); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_muldiv;
        logic [3:0]   ops [10] = '{4'h9, 4'hA, 4'hB, 4'hA, 4'hB, 4'h9, 4'hA, 4'hB, 4'hA, 4'hB};
        logic [W-1:0] as  [10] = '{32'hFFFF, 32'd100, 32'd100, 32'd100, 32'd100,
                                   32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd0};
        logic [W-1:0] bs  [10] = '{32'hFFFF, 32'd0, 32'd0, 32'd7, 32'd7,
                                   32'h9ABCDEF0, 32'd3, 32'd10, 32'd7, 32'd5};
        exp_t e;
        int   lat;
        bit   sawr;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], as[i], bs[i], e, lat, sawr);
            checks++;
            if (bus.aluRes !== e.res || bus.zero !== e.z || bus.illegal !== e.ill) begin
                failures++;
                $display("FAIL muldiv_result op=%h a=%h b=%h got=%h/%b/%b required=%h/%b/%b", ops[i], as[i],
                         bs[i], bus.aluRes, bus.zero, bus.illegal, e.res, e.z, e.ill);
            end
            checks++;
            if (lat != exp_lat(ops[i])) begin
                failures++; $display("FAIL muldiv_latency op=%h got=%0d required=%0d", ops[i], lat, exp_lat(ops[i]));
            end
            checks++;
            if (sawr !== 1'b0) begin failures++; $display("FAIL muldiv_busy_in_ready op=%h got=1 required=0", ops[i]); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_illegal;
        logic [3:0] ops [7] = '{4'h3, 4'h4, 4'h5, 4'hC, 4'hD, 4'hE, 4'hF};
        exp_t e;
        int   lat;
        bit   sawr;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], $urandom | 32'h1, $urandom | 32'h1, e, lat, sawr);
            checks++;
            if (bus.illegal !== 1'b1 || bus.aluRes !== '0 || bus.zero !== 1'b1 || lat != 1) begin
                failures++;
                $display("FAIL illegal_op op=%h got=%h/%b/%b lat=%0d required=0/1/1 lat=1", ops[i],
                         bus.aluRes, bus.zero, bus.illegal, lat);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_hold;
        exp_t         e_old, e_new;
        int           lat;
        bit           sawr;
        bus.out_ready = 1'b0;
        run_op(4'h2, 32'h11, 32'h22, e_old, lat, sawr);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.aluRes !== e_old.res || bus.zero !== e_old.z) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got=v%b r%b %h required=v1 r0 %h", k, bus.out_valid,
                         bus.in_ready, bus.aluRes, e_old.res);
            end
            @(negedge clk); #1;
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = 4'h2;
        bus.input1 = 32'h100;
        bus.input2 = 32'h200;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL hold_b2b_ready got=%b required=1", bus.in_ready); end
        else sb_q.push_back(model(4'h2, 32'h100, 32'h200));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.input1 = $urandom;
        #1;
        e_new = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.aluRes !== e_new.res) begin
            failures++;
            $display("FAIL hold_b2b_result got=v%b %h required=v1 %h", bus.out_valid, bus.aluRes, e_new.res);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back;
        localparam int N = 8;
        logic [3:0]   bop [N] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h2, 4'h6};
        logic [W-1:0] ba [N], bb [N];
        exp_t         e;
        int           sent = 0, got = 0, cyc = 0;
        for (int i = 0; i < N; i++) begin
            ba[i] = $urandom;
            bb[i] = (i == N - 1) ? ba[i] : $urandom;
        end
        bus.out_ready = 1'b1;
        while ((sent < N || got < N) && cyc < 100) begin
            bus.in_valid = (sent < N);
            if (sent < N) begin
                bus.op = bop[sent];
                bus.input1 = ba[sent];
                bus.input2 = bb[sent];
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
                checks++;
                if (bus.aluRes !== e.res || bus.zero !== e.z || bus.illegal !== e.ill) begin
                    failures++;
                    $display("FAIL b2b_result idx=%0d got=%h/%b/%b required=%h/%b/%b", got,
                             bus.aluRes, bus.zero, bus.illegal, e.res, e.z, e.ill);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(model(bop[sent], ba[sent], bb[sent]));
                sent++;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (cyc != N + 1) begin failures++; $display("FAIL b2b_throughput cycles=%0d required=%0d", cyc, N + 1); end
    endtask

    task automatic test_reset_mid;
        bit   seen = 1'b0;
        exp_t e;
        int   lat;
        bit   sawr;
        bus.out_ready = 1'b0;
        drive_op(4'h9, 32'd1234, 32'd5678);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b required=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b required=1", bus.in_ready); end
        checks++; if (bus.aluRes !== '0) begin failures++; $display("FAIL midreset_aluRes got=%h required=0", bus.aluRes); end
        bus.out_ready = 1'b1;
        repeat (50) begin
            @(negedge clk); #1;
            seen |= bus.out_valid;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_stale_result got=1 required=0"); end
        @(negedge clk);
        run_op(4'h2, 32'd5, 32'd7, e, lat, sawr);
        checks++;
        if (bus.aluRes !== e.res || lat != 1) begin
            failures++; $display("FAIL midreset_recover got=%h lat=%0d required=%h lat=1", bus.aluRes, lat, e.res);
        end
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_illegal();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
